// File: rtl/count_sample_fifo_pkg.sv
// Shared widths and types for the counter-sample FIFO slice.
package count_pkg;
  localparam int CNT_W    = 4;
  localparam int WRAP_W   = 8;
  localparam int WRAP_MAX = 255;

  typedef logic [CNT_W-1:0] cnt_t;
endpackage

// File: rtl/count_sample_fifo_if.sv
// Valid/ready sample stream from the counter-sample FIFO to its consumer.
interface count_sample_fifo_if
  import count_pkg::*;
#(
  parameter int WIDTH = CNT_W
);
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/count_sample_fifo_fifo.sv
// Generic first-word-fall-through FIFO; head is read straight from storage.
module sample_fifo
  import count_pkg::*;
#(
  parameter int WIDTH = CNT_W,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // A simultaneous pop frees the slot, so a push into a full FIFO is accepted.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/count_sample_fifo.sv
// Captures each new counter value into a FWFT FIFO; optional wrap counting
// is enabled by defining COUNT_SAMPLE_WRAP_EN.
module count_sample_fifo
  import count_pkg::*;
#(
  parameter int WIDTH = CNT_W,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     q,
  input  logic                 sample_en,
  count_sample_fifo_if.master  stream,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow,
  output logic [WRAP_W-1:0]    wrap_cnt
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] prev;
  logic             prev_valid;
  logic             push;
  logic             pop;
  logic             drop;
  logic [CW-1:0]    count;

  assign push = sample_en && (!prev_valid || (q != prev));
  assign pop  = stream.out_valid && stream.out_ready;
  assign drop = push && (count == CW'(DEPTH)) && !pop;

  sample_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (q),
    .rdata (stream.out_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign stream.out_valid = !empty;

  // prev tracks q even when the sample is dropped, so a held value never re-pushes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev       <= '0;
      prev_valid <= 1'b0;
    end else if (sample_en) begin
      prev       <= q;
      prev_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     overflow <= 1'b0;
    else if (drop) overflow <= 1'b1;
  end

`ifdef COUNT_SAMPLE_WRAP_EN
  function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
    return (v == WRAP_W'(WRAP_MAX)) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) wrap_cnt <= '0;
    else if (sample_en && prev_valid && (prev == '1) && (q == '0))
      wrap_cnt <= sat_inc(wrap_cnt);
  end
`else
  assign wrap_cnt = '0;
`endif
endmodule

// File: tb/tb_count_sample_fifo.sv
// Directed bench for count_sample_fifo with a queue-based scoreboard.
module tb_count_sample_fifo;
  import count_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] q;
  logic       sample_en;
  logic       full;
  logic       empty;
  logic       overflow;
  logic [7:0] wrap_cnt;

  count_sample_fifo_if #(.WIDTH(4)) stream ();

  count_sample_fifo #(.WIDTH(4), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .q         (q),
    .sample_en (sample_en),
    .stream    (stream),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .wrap_cnt  (wrap_cnt)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  logic [3:0] sb[$];
  logic [3:0] m_prev;
  logic       m_pv;
  logic       m_ov;
  int         m_wrap;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_prev = '0;
    m_pv   = 1'b0;
    m_ov   = 1'b0;
    m_wrap = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".valid"}, 32'(stream.out_valid), 32'(sb.size() > 0));
    chk({tag, ".empty"}, 32'(empty), 32'(sb.size() == 0));
    chk({tag, ".full"}, 32'(full), 32'(sb.size() == DEPTH));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ov));
    chk({tag, ".wrap_cnt"}, 32'(wrap_cnt), 32'(m_wrap));
    if (sb.size() > 0) chk({tag, ".head"}, 32'(stream.out_data), 32'(sb[0]));
  endtask

  // Apply one rising edge with the currently driven inputs, updating the model.
  task automatic step(input string tag);
    bit do_pop;
    bit push_req;
    do_pop   = stream.out_ready && (sb.size() > 0);
    push_req = sample_en && (!m_pv || (q != m_prev));
    if (do_pop) begin
      chk({tag, ".popdata"}, 32'(stream.out_data), 32'(sb[0]));
      void'(sb.pop_front());
    end
    if (push_req) begin
      if (sb.size() < DEPTH) sb.push_back(q);
      else m_ov = 1'b1;
    end
`ifdef COUNT_SAMPLE_WRAP_EN
    if (sample_en && m_pv && (m_prev == 4'hF) && (q == 4'h0) && (m_wrap < 255)) m_wrap++;
`endif
    if (sample_en) begin
      m_prev = q;
      m_pv   = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    chk_state(tag);
  endtask

  // Reset is raised between edges so its asynchronous effect is visible before any clock.
  task automatic apply_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk_state(tag);
    chk({tag, ".data0"}, 32'(stream.out_data), 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    logic [3:0] wseq [8];
    wseq = '{4'd14, 4'd15, 4'd0, 4'd1, 4'd14, 4'd15, 4'd0, 4'd1};
    reset = 1'b1;
    q = '0;
    sample_en = 1'b0;
    stream.out_ready = 1'b0;
    model_reset();

    apply_reset("rst0");

    // Held value: a single push, then nothing.
    q = 4'd5;
    sample_en = 1'b1;
    repeat (3) step("hold5");

    // Fill, stream through while full, then overflow and drain.
    apply_reset("rst1");
    for (int i = 0; i < 4; i++) begin
      q = 4'(i);
      step("fill");
    end
    stream.out_ready = 1'b1;
    for (int i = 4; i < 8; i++) begin
      q = 4'(i);
      step("pushpop");
    end
    stream.out_ready = 1'b0;
    q = 4'd8;
    step("drop");
    sample_en = 1'b0;
    stream.out_ready = 1'b1;
    repeat (5) step("drain");

    // Wrap sequence 14,15,0,1 twice.
    apply_reset("rst2");
    sample_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      q = wseq[i];
      step("wrap");
    end

    // Disabled sampling holds prev.
    apply_reset("rst3");
    stream.out_ready = 1'b0;
    q = 4'd3;
    step("en_a");
    sample_en = 1'b0;
    q = 4'd7;
    repeat (2) step("en_off");
    sample_en = 1'b1;
    repeat (2) step("en_on");

    // Asynchronous reset with three entries held and overflow set.
    apply_reset("rst4");
    for (int i = 0; i < 5; i++) begin
      q = 4'(i);
      step("pre");
    end
    sample_en = 1'b0;
    stream.out_ready = 1'b1;
    step("pre_pop");
    stream.out_ready = 1'b0;
    apply_reset("rst_mid");
    sample_en = 1'b1;
    step("post_rst");

`ifdef COUNT_SAMPLE_WRAP_EN
    // Saturation of the wrap counter.
    apply_reset("rst5");
    stream.out_ready = 1'b1;
    repeat (260) begin
      q = 4'hF;
      step("sat_hi");
      q = 4'h0;
      step("sat_lo");
    end
    chk("sat.final", 32'(wrap_cnt), 32'd255);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/count_sample_fifo.md
# count_sample_fifo

Downstream consumer of the 4-bit counter register. Watches the counter output every clock, captures each new value into a small first-word-fall-through FIFO, and presents the samples on a valid/ready handshake to the next stage (display or bus logic). Optionally counts counter wrap-arounds (15 -> 0) and flags dropped samples when the FIFO is full.

## Interface
Parameters:
- WIDTH, 4, counter value width; must match the counter register output.
- DEPTH, 4, FIFO entries; power of two, 2..16.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- q  input  WIDTH  counter value from the counter register.
- sample_en  input  1  when low, q is ignored (no push, prev unchanged).
- out_data  output  WIDTH  FIFO head; valid only while out_valid=1.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head when out_valid&&out_ready at a rising edge.
- full  output  1  FIFO holds DEPTH entries.
- empty  output  1  FIFO holds 0 entries (equals !out_valid).
- overflow  output  1  sticky; a sample was dropped; cleared only by reset.
- wrap_cnt  output  8  number of detected wraps, saturating at 255.

## Operation
- Reset values: out_data=0, out_valid=0, full=0, empty=1, overflow=0, wrap_cnt=0; internal prev=0, prev_valid=0, pointers=0, count=0.
- Change detect (per edge, sample_en=1): if prev_valid=0 -> push q, prev<=q, prev_valid<=1. Else if q!=prev -> push q, prev<=q. Else no push.
- sample_en=0: no push, prev and prev_valid hold.
- Push when not full: write at wr_ptr, wr_ptr increments modulo DEPTH.
- Pop when out_valid&&out_ready: rd_ptr increments modulo DEPTH.
- Push and pop same edge: both occur, count unchanged; allowed when full (no drop) and when count=1.
- Push when full without pop: sample discarded, overflow<=1, prev still updated to q.
- Pop when empty: ignored; no pointer movement.
- Occupancy counter width clog2(DEPTH)+1; full = (count==DEPTH), empty = (count==0).
- Wrap detect: prev_valid=1, prev=={WIDTH{1}}, q==0, sample_en=1 -> wrap_cnt+1 (saturate at 255). Independent of FIFO full state.

## Timing
- q stable before rising edge E -> pushed at E; out_valid/out_data reflect it immediately after E (1-cycle latency, registered).
- out_data is FWFT: head visible combinationally from the storage array while out_valid=1; pop at E shows next entry after E.
- full/empty/overflow/wrap_cnt all registered; update on the same edge as the push/pop causing them.
- reset asserted mid-operation: all outputs to reset values asynchronously; first edge after release with sample_en=1 pushes the current q (prev_valid=0 path).

## Configuration
- COUNT_SAMPLE_WRAP_EN defined: wrap detection and saturating wrap_cnt as above.
- Not defined: wrap logic omitted, wrap_cnt tied to 0; all FIFO behaviour unchanged; port list identical.

## Structure
- Package count_pkg: CNT_W=4, WRAP_W=8, WRAP_MAX=255, typedef cnt_t (logic [CNT_W-1:0]).
- Sub-module sample_fifo: generic FWFT FIFO (WIDTH, DEPTH, push, pop, wdata, rdata, full, empty, count). Top holds change detector, overflow flag and wrap counter.

## Test plan
- Reset then q held at 5, sample_en=1, out_ready=0: one entry (5) pushed on first edge, out_valid=1, no further pushes while q=5.
- q counts 0..3 each cycle, out_ready=0, DEPTH=4: full=1 after 4th edge, out_data=0; q=4 next edge -> overflow=1, contents stay 0,1,2,3.
- Full FIFO, out_ready=1, q changing each cycle: push+pop every edge, full stays 1, overflow stays 0, out_data walks 0,1,2,...
- q counts 14,15,0,1 twice with WRAP_EN: wrap_cnt=2; without macro wrap_cnt=0.
- sample_en=0 while q changes 3->7, then sample_en=1 with q=7: no push (prev=3 until enable? prev held at 3 -> push 7 once).
- reset asserted between edges with 3 entries stored: out_valid=0, overflow=0, wrap_cnt=0 immediately, before next edge.
